// File: rtl/clock_pkg.sv
// Shared definitions for digital_clock and alarm_controller.
//   - watch word layout {hours, minutes, seconds}, binary fields
//   - stored alarm word layout {hours, minutes}
//   - legal range limits for hours and minutes
//   - alarm state encoding
package clock_pkg;

    localparam int WATCH_W  = 17;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;

    localparam int HOUR_LSB = 12;
    localparam int MIN_LSB  = 6;
    localparam int SEC_LSB  = 0;

    localparam int ALARM_W        = HOUR_W + MIN_W;
    localparam int ALARM_HOUR_LSB = MIN_W;
    localparam int ALARM_MIN_LSB  = 0;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/alarm_controller.sv
// Alarm sequencer: stores an alarm time, fires when the watch reaches
// hh:mm:00 while armed, rings for a bounded time and supports a limited
// number of snoozes per alarm event.
//
// Ports
//   clk            1 Hz system clock, rising edge
//   rst            asynchronous active-high reset
//   watch          current time {hours, minutes, seconds}
//   alarm_hours    hour to load (0-23)
//   alarm_minutes  minute to load (0-59)
//   load_alarm     strobe capturing alarm_hours/alarm_minutes
//   alarm_en       level, alarm armed when high
//   snooze         one-cycle snooze request
//   dismiss        one-cycle dismiss request
//   alarm_time     stored alarm {hours, minutes}
//   ringing        high while ringing
//   snoozing       high while snoozing
//   buzzer         toggles every ringing cycle, low otherwise
//   snooze_left    snoozes remaining for the current event
//
// state   | meaning
// IDLE    | waiting for the watch to reach the alarm time
// RINGING | buzzer active, ring timer running toward auto-stop
// SNOOZE  | buzzer quiet, snooze timer running toward re-ring
module alarm_controller
    import clock_pkg::*;
#(
    parameter int RING_TIMEOUT  = 60,
    parameter int SNOOZE_CYCLES = 300,
    parameter int MAX_SNOOZE    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WATCH_W-1:0]  watch,
    input  logic [HOUR_W-1:0]   alarm_hours,
    input  logic [MIN_W-1:0]    alarm_minutes,
    input  logic                load_alarm,
    input  logic                alarm_en,
    input  logic                snooze,
    input  logic                dismiss,
    output logic [ALARM_W-1:0]  alarm_time,
    output logic                ringing,
    output logic                snoozing,
    output logic                buzzer,
    output logic [1:0]          snooze_left
);

    // A parameter of 1 would give a zero-width timer; keep at least one bit.
    localparam int RING_W = (RING_TIMEOUT  > 1) ? $clog2(RING_TIMEOUT)  : 1;
    localparam int SNZ_W  = (SNOOZE_CYCLES > 1) ? $clog2(SNOOZE_CYCLES) : 1;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_CYCLES - 1);

    alarm_state_t       state;
    logic [RING_W-1:0]  ring_cnt;
    logic [SNZ_W-1:0]   snz_cnt;
    logic               match;
    logic               match_q;
    logic               trigger;
    logic               load_ok;

    logic [HOUR_W-1:0]  watch_hour;
    logic [MIN_W-1:0]   watch_min;
    logic [SEC_W-1:0]   watch_sec;

    assign watch_hour = watch[HOUR_LSB +: HOUR_W];
    assign watch_min  = watch[MIN_LSB  +: MIN_W];
    assign watch_sec  = watch[SEC_LSB  +: SEC_W];

    assign load_ok = (alarm_hours   <= HOUR_W'(MAX_HOUR)) &&
                     (alarm_minutes <= MIN_W'(MAX_MIN));

    assign match = alarm_en &&
                   (watch_hour == alarm_time[ALARM_HOUR_LSB +: HOUR_W]) &&
                   (watch_min  == alarm_time[ALARM_MIN_LSB  +: MIN_W]) &&
                   (watch_sec  == '0);

    // Rising edge only, so a watch value held at hh:mm:00 fires once.
    assign trigger = match && !match_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_time <= '0;
        end else if (load_alarm && load_ok) begin
            alarm_time <= {alarm_hours, alarm_minutes};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            match_q     <= 1'b0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            buzzer      <= 1'b0;
            snooze_left <= 2'd0;
        end else begin
            match_q <= match;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state       <= ST_RINGING;
                        ring_cnt    <= '0;
                        ringing     <= 1'b1;
                        buzzer      <= 1'b1;
                        snooze_left <= 2'(MAX_SNOOZE);
                    end
                end

                ST_RINGING: begin
                    if (!alarm_en || dismiss) begin
                        state    <= ST_IDLE;
                        ring_cnt <= '0;
                        ringing  <= 1'b0;
                        buzzer   <= 1'b0;
                    end else if (snooze && (snooze_left != 2'd0)) begin
                        state       <= ST_SNOOZE;
                        snz_cnt     <= '0;
                        ring_cnt    <= '0;
                        snooze_left <= snooze_left - 2'd1;
                        ringing     <= 1'b0;
                        snoozing    <= 1'b1;
                        buzzer      <= 1'b0;
                    end else if (ring_cnt == RING_LAST) begin
                        state    <= ST_IDLE;
                        ring_cnt <= '0;
                        ringing  <= 1'b0;
                        buzzer   <= 1'b0;
                    end else begin
                        ring_cnt <= ring_cnt + RING_W'(1);
                        buzzer   <= ~buzzer;
                    end
                end

                ST_SNOOZE: begin
                    if (!alarm_en || dismiss) begin
                        state    <= ST_IDLE;
                        snz_cnt  <= '0;
                        snoozing <= 1'b0;
                    end else if (snz_cnt == SNZ_LAST) begin
                        state    <= ST_RINGING;
                        snz_cnt  <= '0;
                        ring_cnt <= '0;
                        snoozing <= 1'b0;
                        ringing  <= 1'b1;
                        buzzer   <= 1'b1;
                    end else begin
                        snz_cnt <= snz_cnt + SNZ_W'(1);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    ring_cnt <= '0;
                    snz_cnt  <= '0;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                    buzzer   <= 1'b0;
                end
            endcase
        end
    end

endmodule
